// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-addressed memory unit.
package mem_pkg;

   localparam int LAT_W         = 4;
   localparam int DEF_ADDR_W    = 8;
   localparam int DEF_INS_BYTES = 2;

   typedef enum logic [1:0] {
      S_INIT = 2'd0,
      S_IDLE = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   function automatic int ins_width(input int ins_bytes);
      return ins_bytes * 8;
   endfunction

endpackage

// File: rtl/byte_mem_unit_ram.sv
// 2**ADDR_W x 8 storage with TAPS asynchronous read taps and one synchronous write port.
module byte_ram_nr1w #(
   parameter int ADDR_W = 8,
   parameter int TAPS   = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [7:0]        wdata,
   input  logic [ADDR_W-1:0] raddr [TAPS],
   output logic [7:0]        rdata [TAPS]
);

   logic [7:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   // Reads see the pre-edge contents, giving read-before-write at the top level.
   always_comb begin
      for (int i = 0; i < TAPS; i++) rdata[i] = mem[raddr[i]];
   end

endmodule

// File: rtl/byte_mem_unit.sv
// Byte memory unit: big-endian fetch port plus req/ack data port with programmable
// wait states, and an optional zeroing sweep of the array after reset.
//
//   state  | meaning
//   INIT   | clear sweep, one byte per cycle; data and fetch ports closed
//   IDLE   | data port ready, fetch port open
//   WAIT   | latency count-down; d_ack when the counter reaches zero
module byte_mem_unit
   import mem_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = 8,
   parameter int INS_BYTES      = DEF_INS_BYTES,
   parameter int LATENCY        = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                               clk,
   input  logic                               rst,
   output logic                               init_done,
   input  logic                               if_req,
   input  logic [ADDR_W-1:0]                  if_addr,
   output logic [ins_width(INS_BYTES)-1:0]    if_ins,
   output logic                               if_valid,
   input  logic                               d_req,
   input  logic                               d_we,
   input  logic [ADDR_W-1:0]                  d_addr,
   input  logic [DATA_W-1:0]                  d_wdata,
   output logic                               d_ready,
   output logic [DATA_W-1:0]                  d_rdata,
   output logic                               d_ack
);

   localparam int INS_W = ins_width(INS_BYTES);
   localparam int TAPS  = INS_BYTES + 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

   if (DATA_W != 8) begin : g_bad_data_w
      $error("byte_mem_unit: DATA_W must be 8");
   end
   if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("byte_mem_unit: LATENCY must be 1..15");
   end

   state_t            state, state_nx;
   logic [LAT_W-1:0]  lat, lat_nx;
   logic [ADDR_W-1:0] clr, clr_nx;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [7:0]        ram_wdata;
   logic [ADDR_W-1:0] raddr [TAPS];
   logic [7:0]        rdata [TAPS];
   logic              accept;
   logic              fetch;
   logic [INS_W-1:0]  ins_nx;

   byte_ram_nr1w #(
      .ADDR_W (ADDR_W),
      .TAPS   (TAPS)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (raddr),
      .rdata (rdata)
   );

   // Taps 0..INS_BYTES-1 serve the fetch word (wrapping), the last tap serves loads.
   always_comb begin
      for (int i = 0; i < INS_BYTES; i++) raddr[i] = if_addr + ADDR_W'(i);
      raddr[INS_BYTES] = d_addr;
      ins_nx = '0;
      for (int j = 0; j < INS_BYTES; j++) ins_nx[(INS_BYTES-1-j)*8 +: 8] = rdata[j];
   end

   always_comb begin
      state_nx  = state;
      lat_nx    = lat;
      clr_nx    = clr;
      ram_we    = 1'b0;
      ram_waddr = d_addr;
      ram_wdata = d_wdata;
      accept    = 1'b0;
      fetch     = 1'b0;
      d_ack     = 1'b0;
      unique case (state)
         S_INIT: begin
            ram_we    = 1'b1;
            ram_waddr = clr;
            ram_wdata = '0;
            clr_nx    = clr + 1'b1;
            if (clr == '1) state_nx = S_IDLE;
         end
         S_IDLE: begin
            fetch = if_req;
            if (d_req && d_ready) begin
               accept   = 1'b1;
               ram_we   = d_we;
               lat_nx   = LAT_LOAD;
               state_nx = S_WAIT;
            end
         end
         S_WAIT: begin
            fetch = if_req;
            if (lat == '0) begin
               d_ack    = 1'b1;
               state_nx = S_IDLE;
            end else begin
               lat_nx = lat - 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase
      if (rst) ram_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         if (CLEAR_ON_RESET) state <= S_INIT;
         else                state <= S_IDLE;
         lat       <= '0;
         clr       <= '0;
         init_done <= 1'b0;
         if_ins    <= '0;
         if_valid  <= 1'b0;
         d_ready   <= 1'b0;
         d_rdata   <= '0;
      end else begin
         state     <= state_nx;
         lat       <= lat_nx;
         clr       <= clr_nx;
         init_done <= (state_nx != S_INIT);
         d_ready   <= (state_nx == S_IDLE);
         if_valid  <= fetch;
         if (fetch) if_ins <= ins_nx;
         if (accept && !d_we) d_rdata <= rdata[INS_BYTES];
      end
   end

endmodule

// File: tb/tb_byte_mem_unit.sv
// Scoreboard bench for byte_mem_unit: reference byte array, expected load/fetch queues.
module tb_byte_mem_unit;

   localparam int LATENCY = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        init_done;
   logic        if_req = 1'b0;
   logic [7:0]  if_addr = '0;
   logic [15:0] if_ins;
   logic        if_valid;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [7:0]  d_addr = '0;
   logic [7:0]  d_wdata = '0;
   logic        d_ready;
   logic [7:0]  d_rdata;
   logic        d_ack;

   int errors = 0;
   int checks = 0;

   logic [7:0]  mdl [256];
   logic [7:0]  rd_model;
   logic [7:0]  dq [$];
   logic [15:0] fq [$];

   byte_mem_unit #(
      .ADDR_W         (8),
      .DATA_W         (8),
      .INS_BYTES      (2),
      .LATENCY        (LATENCY),
      .CLEAR_ON_RESET (1'b1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .init_done (init_done),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_ins    (if_ins),
      .if_valid  (if_valid),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_ready   (d_ready),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < 256; i++) mdl[i] = 8'h00;
      rd_model = 8'h00;
   endtask

   // Called right after rst is released at a negedge; counts edges until init_done.
   task automatic wait_init();
      int n;
      n = 0;
      if_req  = 1'b1;
      if_addr = 8'h00;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 3)   chk("init_no_fetch", if_valid, 0);
         if (n == 5)   if_req = 1'b0;
         if (n == 100) chk("init_ready", d_ready, 0);
      end while (!init_done && n < 400);
      chk("init_cycles", n, 256);
   endtask

   task automatic do_data(input bit we, input logic [7:0] addr, input logic [7:0] wd,
                          input bit hold);
      int n, low, ack_at, acks;
      @(negedge clk);
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      n = 0;
      while (!d_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!d_ready) begin
         chk("accept_timeout", 0, 1);
         d_req = 1'b0;
         return;
      end
      @(posedge clk);
      if (we) mdl[addr] = wd;
      else    rd_model = mdl[addr];
      dq.push_back(rd_model);
      low = 0; ack_at = 0; acks = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (!hold) d_req = 1'b0;
         if (d_ack) begin
            acks++;
            ack_at = k;
         end
         if (d_ready) begin
            d_req = 1'b0;
            break;
         end
         low++;
      end
      chk("ready_low", low, LATENCY);
      chk("ack_at", ack_at, LATENCY);
      chk("ack_count", acks, 1);
   endtask

   task automatic do_fetch(input logic [7:0] addr);
      logic [7:0] a1;
      a1 = addr + 8'd1;
      @(negedge clk);
      if_req = 1'b1; if_addr = addr;
      @(posedge clk);
      fq.push_back({mdl[addr], mdl[a1]});
      @(negedge clk);
      if_req = 1'b0;
      chk("fetch_valid", if_valid, 1);
      @(negedge clk);
      chk("fetch_pulse", if_valid, 0);
   endtask

   initial begin
      logic [7:0] ra, rv;
      int n;
      clear_model();

      fork
         forever begin
            @(negedge clk);
            if (!rst) begin
               if (d_ack) begin
                  if (dq.size() == 0) chk("ack_unexpected", 1, 0);
                  else chk("ack_rdata", d_rdata, dq.pop_front());
               end
               if (if_valid) begin
                  if (fq.size() == 0) chk("fetch_unexpected", 1, 0);
                  else chk("fetch_ins", if_ins, fq.pop_front());
               end
            end
         end
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("rst_init_done", init_done, 0);
      chk("rst_d_ready", d_ready, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_if_ins", if_ins, 0);
      @(negedge clk);
      rst = 1'b0;
      wait_init();

      do_data(1'b0, 8'h42, 8'h00, 1'b0);
      chk("load_42", d_rdata, 8'h00);

      do_data(1'b1, 8'h10, 8'hA5, 1'b0);
      do_data(1'b0, 8'h10, 8'h00, 1'b0);
      chk("load_a5", d_rdata, 8'hA5);

      do_data(1'b1, 8'hFF, 8'h12, 1'b0);
      do_data(1'b1, 8'h00, 8'h34, 1'b0);
      chk("store_keeps_rdata", d_rdata, 8'hA5);
      do_fetch(8'hFF);
      chk("fetch_wrap", if_ins, 16'h1234);

      // Same-edge store and fetch at 0x20, then a back-to-back fetch of the new byte.
      @(negedge clk);
      chk("t4_ready", d_ready, 1);
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h20; d_wdata = 8'h77;
      if_req = 1'b1; if_addr = 8'h20;
      @(posedge clk);
      fq.push_back({mdl[8'h20], mdl[8'h21]});
      dq.push_back(rd_model);
      mdl[8'h20] = 8'h77;
      @(negedge clk);
      d_req = 1'b0;
      chk("t4_old", if_ins[15:8], 8'h00);
      @(posedge clk);
      fq.push_back({mdl[8'h20], mdl[8'h21]});
      @(negedge clk);
      if_req = 1'b0;
      chk("t4_new", if_ins[15:8], 8'h77);
      n = 0;
      while (!d_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("t4_done", d_ready, 1);

      do_data(1'b0, 8'h10, 8'h00, 1'b1);
      chk("held_load", d_rdata, 8'hA5);

      for (int it = 0; it < 24; it++) begin
         ra = 8'h80 + 8'($urandom_range(0, 15));
         rv = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 2))
            0:       do_data(1'b1, ra, rv, 1'b0);
            1:       do_data(1'b0, ra, 8'h00, 1'b0);
            default: do_fetch(ra);
         endcase
      end

      do_data(1'b1, 8'h90, 8'h5A, 1'b0);
      do_data(1'b0, 8'h90, 8'h00, 1'b0);
      chk("pre_rst_load", d_rdata, 8'h5A);

      // Reset while a store sits in WAIT: its ack is dropped and the sweep restarts.
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = 8'h55; d_wdata = 8'h99;
      @(posedge clk);
      @(negedge clk);
      d_req = 1'b0;
      chk("t6_in_wait", d_ready, 0);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("t6_ready", d_ready, 0);
      chk("t6_init_done", init_done, 0);
      chk("t6_ack", d_ack, 0);
      chk("t6_rdata", d_rdata, 8'h00);
      dq.delete();
      fq.delete();
      clear_model();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      wait_init();
      do_data(1'b0, 8'h55, 8'h00, 1'b0);
      chk("t6_cleared", d_rdata, 8'h00);
      do_data(1'b0, 8'h10, 8'h00, 1'b0);
      chk("t6_cleared_a5", d_rdata, 8'h00);

      repeat (3) @(negedge clk);
      chk("dq_empty", dq.size(), 0);
      chk("fq_empty", fq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
